// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// Build option MDU_DIRECT_WB_EN is consumed by regfile_wb_arbiter, not here.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  // One MDU result waiting for a free write-port slot.
  typedef struct packed {
    reg_addr_t rd;
    xlen_t     data;
  } wb_entry_t;

  // Which source owns the register-file write port in the current cycle.
  typedef enum logic [1:0] {
    WB_SRC_NONE   = 2'd0,
    WB_SRC_PIPE   = 2'd1,
    WB_SRC_BUF    = 2'd2,
    WB_SRC_DIRECT = 2'd3
  } wb_src_e;

  // Register 0 is hard-wired to zero, so it never counts as pending.
  function automatic logic reg_is_pending(input logic [NUM_REGS-1:0] pend,
                                          input logic                used,
                                          input reg_addr_t           addr);
    return used && (addr != '0) && pend[addr];
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Signal bundle between the core pipeline / MDU and the write-back arbiter.
// Build option MDU_DIRECT_WB_EN does not change this bundle.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  // MEM/WB-stage write request (no handshake: the pipeline always wins).
  logic      PIPE_WE;
  reg_addr_t PIPE_ADDR;
  xlen_t     PIPE_DATA;

  // Op leaving EX toward the multi-cycle MDU; marks its rd as pending.
  logic      MDU_ISSUE;
  reg_addr_t MDU_ISSUE_RD;

  // MDU result handshake: a result transfers on a rising CLK edge exactly
  // when MDU_VALID && MDU_READY; MDU_READY depends only on buffer state,
  // never on MDU_VALID, so the MDU may hold VALID until it sees READY.
  logic      MDU_VALID;
  reg_addr_t MDU_RD;
  xlen_t     MDU_DATA;
  logic      MDU_READY;

  // Decode-stage hazard query.
  reg_addr_t RS1_ADDR;
  reg_addr_t RS2_ADDR;
  logic      RS1_USED;
  logic      RS2_USED;
  reg_addr_t ID_RD;
  logic      ID_WE;
  logic      STALL;

  // Register-file write port and pending-register scoreboard.
  logic                RF_WE;
  reg_addr_t           RF_ADDR;
  xlen_t               RF_DATA;
  logic [NUM_REGS-1:0] PENDING;

  modport slave (
    input  PIPE_WE, PIPE_ADDR, PIPE_DATA,
    input  MDU_ISSUE, MDU_ISSUE_RD,
    input  MDU_VALID, MDU_RD, MDU_DATA,
    output MDU_READY,
    input  RS1_ADDR, RS2_ADDR, RS1_USED, RS2_USED, ID_RD, ID_WE,
    output STALL,
    output RF_WE, RF_ADDR, RF_DATA,
    output PENDING
  );

  modport master (
    output PIPE_WE, PIPE_ADDR, PIPE_DATA,
    output MDU_ISSUE, MDU_ISSUE_RD,
    output MDU_VALID, MDU_RD, MDU_DATA,
    input  MDU_READY,
    output RS1_ADDR, RS2_ADDR, RS1_USED, RS2_USED, ID_RD, ID_WE,
    input  STALL,
    input  RF_WE, RF_ADDR, RF_DATA,
    input  PENDING
  );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// In-order buffer of MDU results waiting for the register-file write port.
// Independent of build option MDU_DIRECT_WB_EN.
module wb_result_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (rst) !(push_i && full_o));
  a_no_pop_when_empty : assert property (
    @(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the pipeline and the MDU.
// Optional MDU_DIRECT_WB_EN: an MDU result bypasses the empty buffer when the port is free.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int BUF_DEPTH = 2  // legal 2..4
) (
  input logic                 CLK,
  input logic                 RESET,
  regfile_wb_arbiter_if.slave bus
);

  logic                pipe_wr;
  logic                mdu_accept;
  logic                mdu_keep;
  logic                direct_wr;
  logic                buf_push;
  logic                buf_pop;
  logic                buf_full;
  logic                buf_empty;
  logic                mdu_wr;
  wb_entry_t           buf_head;
  wb_entry_t           mdu_entry;
  wb_src_e             wb_src;
  logic                rf_we;
  reg_addr_t           rf_addr;
  xlen_t               rf_data;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  assign mdu_entry = '{rd: bus.MDU_RD, data: bus.MDU_DATA};

  always_comb begin
    pipe_wr    = bus.PIPE_WE && (bus.PIPE_ADDR != '0);
    mdu_accept = bus.MDU_VALID && !buf_full;
    mdu_keep   = mdu_accept && (bus.MDU_RD != '0);
`ifdef MDU_DIRECT_WB_EN
    direct_wr  = mdu_keep && buf_empty && !pipe_wr && !RESET;
`else
    direct_wr  = 1'b0;
`endif
    buf_push   = mdu_keep && !direct_wr;
    buf_pop    = !pipe_wr && !buf_empty && !RESET;
  end

  // Pipeline has fixed priority; buffered results drain oldest first.
  always_comb begin
    wb_src = WB_SRC_NONE;
    if (RESET) begin
      wb_src = WB_SRC_NONE;
    end else if (pipe_wr) begin
      wb_src = WB_SRC_PIPE;
    end else if (!buf_empty) begin
      wb_src = WB_SRC_BUF;
    end else if (direct_wr) begin
      wb_src = WB_SRC_DIRECT;
    end
  end

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = '0;
    rf_data = '0;
    case (wb_src)
      WB_SRC_PIPE: begin
        rf_we   = 1'b1;
        rf_addr = bus.PIPE_ADDR;
        rf_data = bus.PIPE_DATA;
      end
      WB_SRC_BUF: begin
        rf_we   = 1'b1;
        rf_addr = buf_head.rd;
        rf_data = buf_head.data;
      end
      WB_SRC_DIRECT: begin
        rf_we   = 1'b1;
        rf_addr = mdu_entry.rd;
        rf_data = mdu_entry.data;
      end
      default: begin
        rf_we   = 1'b0;
        rf_addr = '0;
        rf_data = '0;
      end
    endcase
  end

  assign mdu_wr = (wb_src == WB_SRC_BUF) || (wb_src == WB_SRC_DIRECT);

  // Set after clear so a re-issue of the same rd on the write edge survives.
  always_comb begin
    pending_d = pending_q;
    if (mdu_wr) begin
      pending_d[rf_addr] = 1'b0;
    end
    if (bus.MDU_ISSUE && (bus.MDU_ISSUE_RD != '0)) begin
      pending_d[bus.MDU_ISSUE_RD] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  wb_result_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk         (CLK),
    .rst         (RESET),
    .push_i      (buf_push),
    .push_data_i (mdu_entry),
    .pop_i       (buf_pop),
    .head_o      (buf_head),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

  // A full buffer stalls decode so bubbles reach WB and free a drain slot.
  assign bus.STALL = reg_is_pending(pending_q, bus.RS1_USED, bus.RS1_ADDR)
                  || reg_is_pending(pending_q, bus.RS2_USED, bus.RS2_ADDR)
                  || reg_is_pending(pending_q, bus.ID_WE,    bus.ID_RD)
                  || buf_full;

  assign bus.MDU_READY = !buf_full;
  assign bus.RF_WE     = rf_we;
  assign bus.RF_ADDR   = rf_addr;
  assign bus.RF_DATA   = rf_data;
  assign bus.PENDING   = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic
// against a queue-based reference model; honours MDU_DIRECT_WB_EN when defined.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int BUF_DEPTH = 2;
  localparam int EXP_W     = 1 + REG_ADDR_W + XLEN + 1 + 1 + NUM_REGS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: result buffer as a queue, scoreboard as a bit array.
  wb_entry_t           m_buf[$];
  logic [NUM_REGS-1:0] m_pend = '0;

  // Directed probes (-1 = not checked this cycle).
  string  pr_name   = "";
  longint pr_we     = -1;
  longint pr_addr   = -1;
  longint pr_data   = -1;
  longint pr_stall  = -1;
  longint pr_ready  = -1;
  longint pr_pend   = -1;
  int     pr_bit    = -1;
  longint pr_bitval = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic hit(input logic used, input reg_addr_t a);
    return used && (a != 5'd0) && m_pend[a];
  endfunction

  // Expected outputs for the inputs now on the bus, then advance the model by one edge.
  task automatic model_cycle();
    logic      we, ready, stall, direct, full, pipe_wr;
    reg_addr_t addr;
    xlen_t     data;
    wb_entry_t h;
    logic [NUM_REGS-1:0] pend_now;
    we = 1'b0; addr = '0; data = '0; direct = 1'b0;
    if (rst) begin
      m_buf.delete();
      m_pend = '0;
      exp_q.push_back({1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0});
      return;
    end
    full     = (m_buf.size() == BUF_DEPTH);
    ready    = !full;
    pend_now = m_pend;
    stall    = full || hit(bus.RS1_USED, bus.RS1_ADDR) || hit(bus.RS2_USED, bus.RS2_ADDR)
               || hit(bus.ID_WE, bus.ID_RD);
    pipe_wr  = bus.PIPE_WE && (bus.PIPE_ADDR != 5'd0);
    if (pipe_wr) begin
      we = 1'b1; addr = bus.PIPE_ADDR; data = bus.PIPE_DATA;
    end else if (m_buf.size() != 0) begin
      h = m_buf.pop_front();
      we = 1'b1; addr = h.rd; data = h.data;
      m_pend[h.rd] = 1'b0;
    end
`ifdef MDU_DIRECT_WB_EN
    else if (bus.MDU_VALID && ready && bus.MDU_RD != 5'd0) begin
      direct = 1'b1;
      we = 1'b1; addr = bus.MDU_RD; data = bus.MDU_DATA;
      m_pend[bus.MDU_RD] = 1'b0;
    end
`endif
    if (bus.MDU_VALID && ready && bus.MDU_RD != 5'd0 && !direct)
      m_buf.push_back('{rd: bus.MDU_RD, data: bus.MDU_DATA});
    if (bus.MDU_ISSUE && bus.MDU_ISSUE_RD != 5'd0)
      m_pend[bus.MDU_ISSUE_RD] = 1'b1;
    exp_q.push_back({we, addr, data, ready, stall, pend_now});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rf_we", 32'(bus.RF_WE), 32'(e[71]));
      if (e[71]) begin
        check("rf_addr", 32'(bus.RF_ADDR), 32'(e[70:66]));
        check("rf_data", bus.RF_DATA, e[65:34]);
      end
      check("mdu_ready", 32'(bus.MDU_READY), 32'(e[33]));
      check("stall", 32'(bus.STALL), 32'(e[32]));
      check("pending", bus.PENDING, e[31:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.PIPE_WE = 1'b0; bus.PIPE_ADDR = '0; bus.PIPE_DATA = '0;
    bus.MDU_ISSUE = 1'b0; bus.MDU_ISSUE_RD = '0;
    bus.MDU_VALID = 1'b0; bus.MDU_RD = '0; bus.MDU_DATA = '0;
    bus.RS1_ADDR = '0; bus.RS2_ADDR = '0; bus.RS1_USED = 1'b0; bus.RS2_USED = 1'b0;
    bus.ID_RD = '0; bus.ID_WE = 1'b0;
  endtask

  task automatic probe(input string name, input longint we, input longint addr,
                       input longint data, input longint stall, input longint ready);
    pr_name = name; pr_we = we; pr_addr = addr; pr_data = data;
    pr_stall = stall; pr_ready = ready;
  endtask

  // One clock: model, spec-constant probes at the falling edge, then the next drive slot.
  task automatic step();
    model_cycle();
    @(negedge clk);
    if (pr_we >= 0)     check({pr_name, "_we"},    32'(bus.RF_WE),     32'(pr_we));
    if (pr_addr >= 0)   check({pr_name, "_addr"},  32'(bus.RF_ADDR),   32'(pr_addr));
    if (pr_data >= 0)   check({pr_name, "_data"},  bus.RF_DATA,        32'(pr_data));
    if (pr_stall >= 0)  check({pr_name, "_stall"}, 32'(bus.STALL),     32'(pr_stall));
    if (pr_ready >= 0)  check({pr_name, "_ready"}, 32'(bus.MDU_READY), 32'(pr_ready));
    if (pr_pend >= 0)   check({pr_name, "_pend"},  bus.PENDING,        32'(pr_pend));
    if (pr_bit >= 0)    check({pr_name, "_pbit"},  32'(bus.PENDING[pr_bit]), 32'(pr_bitval));
    pr_name = ""; pr_we = -1; pr_addr = -1; pr_data = -1; pr_stall = -1;
    pr_ready = -1; pr_pend = -1; pr_bit = -1; pr_bitval = -1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int rd);
    idle(); bus.MDU_ISSUE = 1'b1; bus.MDU_ISSUE_RD = 5'(rd); step();
  endtask

  task automatic set_pipe(input int rd, input int data);
    bus.PIPE_WE = 1'b1; bus.PIPE_ADDR = 5'(rd); bus.PIPE_DATA = 32'(data);
  endtask

  task automatic set_mdu(input int rd, input int data);
    bus.MDU_VALID = 1'b1; bus.MDU_RD = 5'(rd); bus.MDU_DATA = 32'(data);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with a pipe write and an issue that must both be ignored.
    set_pipe(4, 32'h44); bus.MDU_ISSUE = 1'b1; bus.MDU_ISSUE_RD = 5'd9;
    probe("reset", 0, -1, -1, 0, 1); pr_pend = 0; step();
    probe("reset2", 0, -1, -1, 0, 1); pr_pend = 0; step();
    rst = 1'b0; idle();
    probe("post_reset", 0, -1, -1, 0, 1); pr_pend = 0; step();

    // Single MDU result rd=5, idle pipe.
    issue(5);
    idle(); set_mdu(5, 32'h1234); pr_bit = 5; pr_bitval = 1;
`ifdef MDU_DIRECT_WB_EN
    probe("r5_direct", 1, 5, 32'h1234, -1, 1);
`else
    probe("r5_accept", 0, -1, -1, -1, 1);
`endif
    step();
    idle();
`ifdef MDU_DIRECT_WB_EN
    probe("r5_after", 0, -1, -1, -1, -1); pr_bit = 5; pr_bitval = 0;
`else
    probe("r5_write", 1, 5, 32'h1234, -1, -1);
`endif
    step();
    idle(); pr_name = "r5_clear"; pr_bit = 5; pr_bitval = 0; step();

    // Pipe hogs the port for 4 cycles while rd7 and rd8 arrive.
    issue(7); issue(8);
    idle(); set_pipe(3, 32'hA0); set_mdu(7, 32'h7777);
    probe("hog0", 1, 3, 32'hA0, -1, 1); step();
    idle(); set_pipe(3, 32'hA1); set_mdu(8, 32'h8888);
    probe("hog1", 1, 3, 32'hA1, -1, 1); step();
    idle(); set_pipe(3, 32'hA2);
    probe("hog2", 1, 3, 32'hA2, 1, 0); step();
    idle(); set_pipe(3, 32'hA3);
    probe("hog3", 1, 3, 32'hA3, 1, 0); step();
    idle(); probe("drain7", 1, 7, 32'h7777, 1, 0); step();
    idle(); probe("drain8", 1, 8, 32'h8888, 0, 1); step();
    idle(); probe("drained", 0, -1, -1, 0, 1); pr_pend = 0; step();

    // RAW hazard on rd10 from decode.
    issue(10);
    idle(); bus.RS1_ADDR = 5'd10; bus.RS1_USED = 1'b1;
    probe("raw_wait0", 0, -1, -1, 1, -1); step();
    probe("raw_wait1", 0, -1, -1, 1, -1); step();
    set_mdu(10, 32'hA10);
`ifdef MDU_DIRECT_WB_EN
    probe("raw_direct", 1, 10, 32'hA10, 1, -1);
`else
    probe("raw_accept", 0, -1, -1, 1, -1);
`endif
    step();
    bus.MDU_VALID = 1'b0;
`ifdef MDU_DIRECT_WB_EN
    probe("raw_free", 0, -1, -1, 0, -1);
`else
    probe("raw_write", 1, 10, 32'hA10, 1, -1);
`endif
    step();
    probe("raw_done", 0, -1, -1, 0, -1); step();

    // Re-issue of rd10 on the edge its older result is written: set wins.
    issue(10);
    idle(); set_mdu(10, 32'hB10);
`ifdef MDU_DIRECT_WB_EN
    bus.MDU_ISSUE = 1'b1; bus.MDU_ISSUE_RD = 5'd10;
    probe("reissue_wr", 1, 10, 32'hB10, -1, -1); step();
`else
    step();
    idle(); bus.MDU_ISSUE = 1'b1; bus.MDU_ISSUE_RD = 5'd10;
    probe("reissue_wr", 1, 10, 32'hB10, -1, -1); step();
`endif
    idle(); pr_name = "reissue_pend"; pr_bit = 10; pr_bitval = 1; step();
    set_mdu(10, 32'hC10); step();
    idle(); step();
    pr_name = "reissue_clr"; pr_bit = 10; pr_bitval = 0; step();

    // Writes to register 0 from either source are dropped.
    for (int i = 0; i < 3; i++) begin
      idle(); set_pipe(0, 32'hDEAD); set_mdu(0, 32'hBEEF);
      bus.MDU_ISSUE = 1'b1; bus.MDU_ISSUE_RD = 5'd0;
      probe("x0", 0, -1, -1, 0, 1); pr_bit = 0; pr_bitval = 0; step();
    end
    idle(); probe("x0_after", 0, -1, -1, 0, 1); pr_pend = 0; step();

    // Reset mid-operation with two buffered results and PENDING=0x480.
    issue(7); issue(10);
    idle(); set_pipe(1, 32'h1); set_mdu(7, 32'h70); step();
    idle(); set_pipe(1, 32'h2); set_mdu(10, 32'hA0); step();
    idle(); set_pipe(1, 32'h3);
    probe("pre_rst", 1, 1, 32'h3, 1, 0); pr_pend = 32'h0000_0480; step();
    rst = 1'b1;
    probe("mid_rst0", 0, -1, -1, 0, 1); pr_pend = 0; step();
    probe("mid_rst1", 0, -1, -1, 0, 1); pr_pend = 0; step();
    rst = 1'b0; idle();
    for (int i = 0; i < 3; i++) begin
      probe("after_rst", 0, -1, -1, 0, 1); pr_pend = 0; step();
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.PIPE_WE      = ($urandom_range(0, 9) < 4);
      bus.PIPE_ADDR    = 5'($urandom_range(0, 31));
      bus.PIPE_DATA    = $urandom;
      bus.MDU_ISSUE    = ($urandom_range(0, 9) < 3);
      bus.MDU_ISSUE_RD = 5'($urandom_range(0, 31));
      bus.MDU_VALID    = ($urandom_range(0, 9) < 4);
      bus.MDU_RD       = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.MDU_DATA     = $urandom;
      bus.RS1_ADDR     = 5'($urandom_range(0, 31));
      bus.RS2_ADDR     = 5'($urandom_range(0, 31));
      bus.RS1_USED     = $urandom_range(0, 1);
      bus.RS2_USED     = $urandom_range(0, 1);
      bus.ID_RD        = 5'($urandom_range(0, 31));
      bus.ID_WE        = $urandom_range(0, 1);
      step();
    end
    rst = 1'b0;
    idle();
    repeat (4) step();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 2, meaning depth of the MDU result buffer (legal values 2..4).
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports PIPE_WE  in 1, PIPE_ADDR  in 5, PIPE_DATA  in 32: MEM/WB-stage write request.
REQ-005 SHALL have ports MDU_ISSUE  in 1, MDU_ISSUE_RD  in 5: M-extension op leaving EX toward the multi-cycle MDU.
REQ-006 SHALL have ports MDU_VALID  in 1, MDU_RD  in 5, MDU_DATA  in 32, MDU_READY  out 1: MDU result handshake.
REQ-007 SHALL have ports RS1_ADDR, RS2_ADDR  in 5, RS1_USED, RS2_USED  in 1, ID_RD  in 5, ID_WE  in 1: decode-stage hazard query.
REQ-008 SHALL have port STALL  out 1  freeze IF/ID and insert a bubble into EX.
REQ-009 SHALL have ports RF_WE  out 1, RF_ADDR  out 5, RF_DATA  out 32: the register file's single write port.
REQ-010 SHALL have port PENDING  out 32  scoreboard, bit n = register n awaits MDU writeback.

Function
REQ-011 SHALL drive the write port combinationally, with the pipeline having fixed priority: if PIPE_WE and PIPE_ADDR!=0, RF_* = PIPE_*.
REQ-012 SHALL otherwise, if the buffer is non-empty, write the buffer head to RF_* and pop it in that cycle.
REQ-013 SHALL drive RF_WE=0 when neither source writes; PIPE_WE with PIPE_ADDR=0 SHALL be dropped, with no write.
REQ-014 SHALL accept an MDU result on a clock edge when MDU_VALID && MDU_READY; MDU_READY = !buffer_full, combinational.
REQ-015 SHALL treat a buffer push and pop in the same cycle on a full buffer as illegal; MDU_READY SHALL stay low whenever the buffer is full.
REQ-016 SHALL discard an accepted MDU result with MDU_RD=0 without buffering it.
REQ-017 SHALL set PENDING[MDU_ISSUE_RD] on the edge where MDU_ISSUE=1 and MDU_ISSUE_RD!=0.
REQ-018 SHALL clear PENDING[RF_ADDR] on the edge where a buffered or direct MDU result is written.
REQ-019 SHALL apply the same-edge set/clear rule: set SHALL win.
REQ-020 SHALL compute STALL = (RS1_USED&&PENDING[RS1_ADDR]) || (RS2_USED&&PENDING[RS2_ADDR]) || (ID_WE&&PENDING[ID_RD]) || buffer_full, purely combinationally.
REQ-021 SHALL ignore register 0 in every STALL term.
REQ-022 SHALL keep minimum MDU-result-to-RF latency at 1 cycle (buffered path) unless REQ-030 applies.
REQ-023 SHALL preserve MDU result order; buffer pointers SHALL wrap modulo BUF_DEPTH.
REQ-024 SHALL keep the pipeline from starving the MDU indefinitely: a full buffer asserts STALL, so bubbles reach WB and a drain slot appears within 3 cycles.

Reset
REQ-025 SHALL, while RESET=1, force buffer empty, PENDING=0, RF_WE=0, MDU_READY=1, STALL=0.
REQ-026 SHALL discard buffered results and clear the scoreboard on reset mid-operation; no write SHALL occur in the reset cycle.
REQ-027 SHALL resume normal arbitration on the first rising CLK edge after RESET deasserts.

Configuration
REQ-028 SHALL honour macro MDU_DIRECT_WB_EN.
REQ-029 SHALL, without MDU_DIRECT_WB_EN, route every MDU result through the buffer, for minimum latency 1.
REQ-030 SHALL, with MDU_DIRECT_WB_EN defined, write an MDU result straight to RF_* in its acceptance cycle when the buffer is empty and the pipeline is not writing, with no push; latency is then 0.

Structure
REQ-031 SHALL place shared constants in package regfile_pkg: REG_ADDR_W=5, XLEN=32, NUM_REGS=32, and the buffer-entry struct {rd, data}.
REQ-032 SHALL implement the result buffer as sub-module wb_result_fifo (push/pop/full/empty/head), instantiated once.

Verification
REQ-033 SHALL test: MDU result rd=5 data=0x1234 with idle pipe -> RF_WE=1, RF_ADDR=5, RF_DATA=0x1234 one cycle later (0 cycles with MDU_DIRECT_WB_EN); PENDING[5] clears.
REQ-034 SHALL test: PIPE_WE rd=3 every cycle for 4 cycles while MDU delivers rd=7 then rd=8 -> pipe writes win; buffer fills; STALL=1, MDU_READY=0; after pipe idles, rd7 then rd8 are written in order.
REQ-035 SHALL test: MDU_ISSUE rd=10, then ID with RS1_ADDR=10, RS1_USED=1 -> STALL=1 until the cycle after rd10 is written, then 0.
REQ-036 SHALL test: MDU_ISSUE rd=10 on the same edge that rd10's earlier result is written -> PENDING[10] remains 1.
REQ-037 SHALL test: PIPE_WE=1, PIPE_ADDR=0, and MDU result rd=0 -> RF_WE never asserts; PENDING[0] stays 0.
REQ-038 SHALL test: RESET pulse with buffer holding 2 entries and PENDING=0x0000_0480 -> PENDING=0, MDU_READY=1, no RF write during or after reset.
